// File: rtl/delay_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : delay_slot_scheduler
//  Description : Shares one prescaled delay timer between N_REQ requesters.
//                Requests are granted round-robin, one at a time. Each grant
//                counts out len ticks of CLK_DIV clock cycles, then pulses
//                the owner's done bit for one cycle.
//  Ports       : C_50Mhz - system clock (only clock)
//                rst     - synchronous active-high reset
//                req_i   - level request per requester, held until done
//                len_i   - packed lengths, slice i = len_i[i*LEN_W +: LEN_W]
//                gnt_o   - one-hot owner of the timer, zero when idle
//                done_o  - one-cycle completion pulse to the owner
//                busy_o  - high whenever the scheduler is not idle
//                tick_o  - one-cycle pulse on each prescaler wrap in COUNT
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_slot_scheduler #(
   parameter int CLK_DIV = 1_000_000,
   parameter int N_REQ   = 4,
   parameter int LEN_W   = 8
) (
   input  logic                     C_50Mhz,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ*LEN_W-1:0]   len_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [N_REQ-1:0]         done_o,
   output logic                     busy_o,
   output logic                     tick_o
);

   localparam int PRE_W = $clog2(CLK_DIV);
   localparam int PTR_W = $clog2(N_REQ);

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [N_REQ-1:0] GNT_ONE = N_REQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PRE_W-1:0]   pre_q,   pre_d;
   logic [LEN_W-1:0]   cnt_q,   cnt_d;
   logic [PTR_W-1:0]   ptr_q,   ptr_d;
   logic [N_REQ-1:0]   gnt_q,   gnt_d;

   // Unpack the length bus so the winner's slice can be picked by index.
   logic [LEN_W-1:0]   len_arr [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
      assign len_arr[gi] = len_i[gi*LEN_W +: LEN_W];
   end

   // Round-robin search: first set request starting just after the last
   // granted index, wrapping modulo N_REQ. The last candidate checked is
   // ptr_q itself, so a lone requester can be re-granted.
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [LEN_W-1:0]   win_len;
   int                 cand_int;
   logic [PTR_W-1:0]   cand_idx;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_len   = '0;
      cand_int  = 0;
      cand_idx  = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand_int = (int'(ptr_q) + off) % N_REQ;
         cand_idx = PTR_W'(cand_int);
         if (!win_found && req_i[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
            win_len   = len_arr[cand_idx];
         end
      end
   end

   always_ff @(posedge C_50Mhz) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= PTR_RST;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      tick_o  = 1'b0;
      done_o  = '0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               gnt_d   = GNT_ONE << win_idx;
               ptr_d   = win_idx;
               cnt_d   = win_len;
               pre_d   = '0;
               // A zero length skips counting so cnt can never underflow.
               state_d = (win_len == '0) ? ST_DONE : ST_COUNT;
            end
         end
         ST_COUNT: begin
            // Owner withdrawal takes priority over a coincident final tick.
            if ((req_i & gnt_q) == '0) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else if (pre_q == PRE_MAX) begin
               tick_o = 1'b1;
               pre_d  = '0;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == LEN_ONE) begin
                  state_d = ST_DONE;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         ST_DONE: begin
            done_o  = gnt_q;
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign gnt_o  = gnt_q;
   assign busy_o = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_delay_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_slot_scheduler
//  Description : Self-checking bench for delay_slot_scheduler with a
//                grant-level reference model (owner, length, elapsed cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_slot_scheduler;

   localparam int D  = 4;
   localparam int N  = 4;
   localparam int LW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*LW-1:0] len;
   logic [N-1:0]    gnt, done;
   logic            busy, tick;

   always #5 clk = ~clk;

   delay_slot_scheduler #(.CLK_DIV(D), .N_REQ(N), .LEN_W(LW)) dut (
      .C_50Mhz (clk),
      .rst     (rst),
      .req_i   (req),
      .len_i   (len),
      .gnt_o   (gnt),
      .done_o  (done),
      .busy_o  (busy),
      .tick_o  (tick)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the timer, the sampled length, and how many
   // cycles have elapsed since the grant.
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_len   = 0;
   int m_el    = 0;
   int m_last  = N - 1;

   // Observation counters, cleared by each scenario.
   int          c_tick, c_busy, c_done;
   bit          saw_done;
   logic [N-1:0] last_done;
   logic [N-1:0] prev_gnt = '0;
   int          gq[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit found;
      int c;
      if (rst) begin
         m_busy = 1'b0;
         m_last = N - 1;
      end else if (!m_busy) begin
         found = 1'b0;
         for (int off = 1; off <= N; off++) begin
            c = (m_last + off) % N;
            if (!found && req[c]) begin
               found   = 1'b1;
               m_owner = c;
               m_last  = c;
               m_len   = int'(len[c*LW +: LW]);
               m_el    = 0;
               m_busy  = 1'b1;
            end
         end
      end else if (m_el == m_len * D) begin
         m_busy = 1'b0;
      end else if (!req[m_owner]) begin
         m_busy = 1'b0;
      end else begin
         m_el++;
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycle();
      logic [N-1:0] eg, ed;
      logic         et;
      #1;
      eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      ed = (m_busy && m_el == m_len * D) ? eg : 4'b0000;
      et = m_busy && (m_el < m_len * D) && req[m_owner] && ((m_el % D) == D - 1);
      check_eq("gnt",  32'(gnt),  32'(eg));
      check_eq("done", 32'(done), 32'(ed));
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("tick", 32'(tick), 32'(et));
      if (tick) c_tick++;
      if (busy) c_busy++;
      if (done != '0) begin
         c_done++;
         saw_done  = 1'b1;
         last_done = done;
      end
      if (gnt != '0 && prev_gnt == '0) begin
         for (int i = 0; i < N; i++) if (gnt[i]) gq.push_back(i);
      end
      prev_gnt = gnt;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic clr();
      c_tick = 0; c_busy = 0; c_done = 0;
      saw_done = 1'b0; last_done = '0;
   endtask

   task automatic set_len(input int idx, input int v);
      len[idx*LW +: LW] = LW'(v);
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1;
      req = 4'b1111;
      len = '0;
      for (int i = 0; i < N; i++) set_len(i, 1);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      clr();

      // Reset held with all requests up; then round-robin contention.
      for (int k = 0; k < 3; k++) cycle();
      rst = 1'b0;
      gq.delete();
      cycle();
      #1 check_eq("rst_first_gnt", 32'(gnt), 32'(4'b0001));
      for (int k = 0; k < 27; k++) cycle();
      check_eq("order_cnt", 32'(gq.size() >= 5), 32'd1);
      if (gq.size() >= 5)
         for (int k = 0; k < 5; k++) check_eq("order", 32'(gq[k]), 32'(exp_order[k]));
      req = '0;
      for (int k = 0; k < 4; k++) cycle();

      // Single grant, length 3.
      clr();
      set_len(2, 3);
      req = 4'b0100;
      for (int k = 0; k < 20 && !saw_done; k++) cycle();
      req = '0;
      check_eq("single_saw_done", 32'(saw_done), 32'd1);
      check_eq("single_done", 32'(last_done), 32'(4'b0100));
      check_eq("single_ticks", 32'(c_tick), 32'd3);
      check_eq("single_busy", 32'(c_busy), 32'd13);
      for (int k = 0; k < 3; k++) cycle();

      // Zero length.
      clr();
      set_len(1, 0);
      req = 4'b0010;
      for (int k = 0; k < 10 && !saw_done; k++) cycle();
      req = '0;
      check_eq("zero_saw_done", 32'(saw_done), 32'd1);
      check_eq("zero_done", 32'(last_done), 32'(4'b0010));
      check_eq("zero_ticks", 32'(c_tick), 32'd0);
      check_eq("zero_busy", 32'(c_busy), 32'd1);
      for (int k = 0; k < 3; k++) cycle();

      // Abort after two ticks, then requester 0 wins next.
      clr();
      set_len(3, 5);
      req = 4'b1000;
      for (int k = 0; k < 40 && c_tick < 2; k++) cycle();
      check_eq("abort_ticks", 32'(c_tick), 32'd2);
      req = '0;
      for (int k = 0; k < 3; k++) cycle();
      check_eq("abort_no_done", 32'(c_done), 32'd0);
      clr();
      set_len(0, 1);
      req = 4'b0001;
      for (int k = 0; k < 12 && !saw_done; k++) cycle();
      req = '0;
      check_eq("after_abort_done", 32'(last_done), 32'(4'b0001));
      for (int k = 0; k < 3; k++) cycle();

      // Reset in the middle of COUNT.
      clr();
      set_len(2, 5);
      req = 4'b0100;
      for (int k = 0; k < 6; k++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      req = '0;
      for (int k = 0; k < 8; k++) cycle();
      check_eq("midrst_no_done", 32'(c_done), 32'd0);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) begin
            if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
            set_len(i, int'($urandom_range(0, 3)));
         end
         rst = ($urandom_range(0, 499) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
